leaf_stream_packetizer: RTL and testbench

- Transmit end of the leaf/BFT packet protocol.
- Accepts one user-side ap_vld/ap_ack 32-bit stream, as produced by an HLS kernel output port.
- Wraps each word into a 49-bit BFT packet carrying destination leaf, destination port and a rolling BRAM slot address.
- Enforces credit-based flow control against the receiving leaf's input buffer.
- Destination and credit returns arrive as control packets on the BFT input bus.
- Sits beside a leaf as a lightweight single-output-port injector.

---
 rtl/leaf_stream_packetizer.sv | 108 ++++++++++
 tb/tb_leaf_stream_packetizer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer: wraps a 32-bit ap_vld/ap_ack user stream into BFT
// packets addressed to a programmed leaf/port, with credit-based flow control
// against the receiving leaf's buffer and a rolling slot address.
module leaf_stream_packetizer #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk_bft,
  input  logic                     reset_n,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user,
  output logic                     ack_user,
  output logic                     configured,
  output logic [NUM_ADDR_BITS:0]   credits
);

  localparam int unsigned CW        = NUM_ADDR_BITS + 1;
  localparam int unsigned DEPTH     = 1 << NUM_ADDR_BITS;
  localparam int unsigned ADDR_LSB  = PAYLOAD_BITS;
  localparam int unsigned PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
  localparam logic [CW:0]   CRED_ADD = (CW + 1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [1:0]    TYPE_CFG = 2'b01;
  localparam logic [1:0]    TYPE_UPD = 2'b10;

  logic [NUM_LEAF_BITS-1:0] dest_leaf;
  logic [NUM_PORT_BITS-1:0] dest_port;
  logic [NUM_ADDR_BITS-1:0] addr;

  logic [PAYLOAD_BITS-1:0]  ctrl_payload;
  logic                     is_ctrl;
  logic                     cfg_hit;
  logic                     upd_hit;
  logic                     send;
  logic [CW:0]              cred_sum;
  logic [CW-1:0]            cred_next;
  logic                     unused_din;

  // Every incoming bit is inspected only through the decode below.
  assign unused_din = ^din_leaf_bft2interface;

  // Control packet decode and send qualification.
  always_comb begin
    ctrl_payload = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    is_ctrl      = din_leaf_bft2interface[PACKET_BITS-1] &&
                   (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0);
    cfg_hit      = is_ctrl && (ctrl_payload[PAYLOAD_BITS-1 -: 2] == TYPE_CFG) &&
                   (ctrl_payload[NUM_PORT_BITS-1:0] != '0);
    upd_hit      = is_ctrl && (ctrl_payload[PAYLOAD_BITS-1 -: 2] == TYPE_UPD);
    send         = vld_user && configured && (credits != '0) && !resend;
  end

  assign ack_user = send;

  // Next credit count: consume one per send, restore on update, saturate at depth.
  always_comb begin
    cred_sum  = {1'b0, credits};
    cred_next = credits;
    if (send) begin
      cred_sum = cred_sum - (CW + 1)'(1);
    end
    if (upd_hit) begin
      cred_sum = cred_sum + CRED_ADD;
    end
    if (cred_sum > {1'b0, CRED_MAX}) begin
      cred_next = CRED_MAX;
    end else begin
      cred_next = cred_sum[CW-1:0];
    end
  end

  // Output packet, slot address, credits and destination registers.
  always_ff @(posedge clk_bft or negedge reset_n) begin
    if (!reset_n) begin
      dout_leaf_interface2bft <= '0;
      configured              <= 1'b0;
      credits                 <= CRED_MAX;
      addr                    <= '0;
      dest_leaf               <= '0;
      dest_port               <= '0;
    end else begin
      if (!resend) begin
        if (send) begin
          dout_leaf_interface2bft <= {1'b1, dest_leaf, dest_port, addr, din_user};
        end else begin
          dout_leaf_interface2bft <= '0;
        end
      end
      if (send) begin
        addr <= addr + NUM_ADDR_BITS'(1);
      end
      credits <= cred_next;
      if (cfg_hit) begin
        dest_leaf  <= ctrl_payload[NUM_PORT_BITS +: NUM_LEAF_BITS];
        dest_port  <= ctrl_payload[NUM_PORT_BITS-1:0];
        configured <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Bench for leaf_stream_packetizer: directed table, hand sequences for credit
// exhaustion/saturation/resend/reset, and random traffic against a reference model.
module tb_leaf_stream_packetizer;

  logic        clk;
  logic        reset_n;
  logic [48:0] din_bft;
  logic [48:0] dout;
  logic        resend;
  logic [31:0] din_user;
  logic        vld_user;
  logic        ack_user;
  logic        configured;
  logic [7:0]  credits;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_cred;
  int          m_addr;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  bit          m_cfg;
  logic [48:0] m_dout;
  bit          last_ack;

  typedef struct {
    logic [48:0] bft;
    logic        r;
    logic        v;
    logic [31:0] d;
    logic        ack;
    logic [48:0] dout;
    int          cred;
  } vec_t;

  vec_t tbl[5];

  leaf_stream_packetizer dut (
    .clk_bft                 (clk),
    .reset_n                 (reset_n),
    .din_leaf_bft2interface  (din_bft),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .din_user                (din_user),
    .vld_user                (vld_user),
    .ack_user                (ack_user),
    .configured              (configured),
    .credits                 (credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] pk(input logic [4:0] l, input logic [3:0] p,
                                     input int a, input logic [31:0] d);
    return {1'b1, l, p, 7'(a), d};
  endfunction

  function automatic logic [48:0] ctl(input logic [31:0] pl);
    return {1'b1, 5'd0, 4'd0, 7'd0, pl};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred = 128;
    m_addr = 0;
    m_leaf = '0;
    m_port = '0;
    m_cfg  = 0;
    m_dout = '0;
  endtask

  // One clock cycle: drive, check ack, advance model, check registered outputs.
  task automatic step(input logic [48:0] b, input logic r, input logic v, input logic [31:0] d);
    bit s;
    bit is_ctrl;
    @(negedge clk);
    din_bft  = b;
    resend   = r;
    vld_user = v;
    din_user = d;
    #1;
    s = v && m_cfg && (m_cred != 0) && !r;
    last_ack = ack_user;
    check("ack", 64'(ack_user), 64'(s));
    @(posedge clk);
    #1;
    is_ctrl = b[48] && (b[42:39] == 4'd0);
    if (!r) m_dout = s ? pk(m_leaf, m_port, m_addr, d) : 49'd0;
    if (s) begin
      m_cred = m_cred - 1;
      m_addr = (m_addr + 1) % 128;
    end
    if (is_ctrl && b[31:30] == 2'b10) m_cred = (m_cred + 64 > 128) ? 128 : m_cred + 64;
    if (is_ctrl && b[31:30] == 2'b01 && b[3:0] != 4'd0) begin
      m_leaf = b[8:4];
      m_port = b[3:0];
      m_cfg  = 1;
    end
    check("dout", 64'(dout), 64'(m_dout));
    check("credits", 64'(credits), 64'(m_cred));
    check("configured", 64'(configured), 64'(m_cfg));
  endtask

  initial begin
    logic [48:0] held;
    logic [31:0] word;
    int          kind;
    logic [48:0] b;

    reset_n  = 1'b1;
    din_bft  = '0;
    resend   = 1'b0;
    din_user = '0;
    vld_user = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_credits", 64'(credits), 64'd128);
    check("rst_configured", 64'(configured), 64'd0);
    check("rst_ack", 64'(ack_user), 64'd0);

    // Unconfigured: valid data must never be acknowledged.
    for (int i = 0; i < 10; i++) begin
      step(49'd0, 1'b0, 1'b1, 32'hA5A5A5A5);
      check("noconf_ack", 64'(last_ack), 64'd0);
      check("noconf_dout", 64'(dout), 64'd0);
    end

    // Directed table: configure leaf 5 port 3, send three words.
    tbl[0] = '{ctl(32'h40000053), 1'b0, 1'b0, 32'h0, 1'b0, 49'd0, 128};
    tbl[1] = '{49'd0, 1'b0, 1'b1, 32'h1, 1'b1, pk(5'd5, 4'd3, 0, 32'h1), 127};
    tbl[2] = '{49'd0, 1'b0, 1'b1, 32'h2, 1'b1, pk(5'd5, 4'd3, 1, 32'h2), 126};
    tbl[3] = '{49'd0, 1'b0, 1'b1, 32'h3, 1'b1, pk(5'd5, 4'd3, 2, 32'h3), 125};
    tbl[4] = '{49'd0, 1'b0, 1'b0, 32'h4, 1'b0, 49'd0, 125};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].bft, tbl[i].r, tbl[i].v, tbl[i].d);
      check("tbl_ack", 64'(last_ack), 64'(tbl[i].ack));
      check("tbl_dout", 64'(dout), 64'(tbl[i].dout));
      check("tbl_credits", 64'(credits), 64'(tbl[i].cred));
    end
    check("tbl_bits", 64'(tbl[1].dout), 64'h1_2980_0000_0001);

    // Exhaust all credits (128 sends total), then the next word stalls.
    for (int i = 0; i < 125; i++) step(49'd0, 1'b0, 1'b1, 32'h100 + 32'(i));
    check("cred_zero", 64'(credits), 64'd0);
    step(49'd0, 1'b0, 1'b1, 32'hDEAD0129);
    check("stall_ack", 64'(last_ack), 64'd0);

    // Freespace update restores 64 credits; sending resumes at wrapped addr 0.
    step(ctl(32'h80000000), 1'b0, 1'b1, 32'hDEAD0129);
    check("upd_ack", 64'(last_ack), 64'd0);
    check("upd_credits", 64'(credits), 64'd64);
    step(49'd0, 1'b0, 1'b1, 32'hDEAD0129);
    check("resume_ack", 64'(last_ack), 64'd1);
    check("addr_wrap", 64'(dout[38:32]), 64'd0);

    // Reach 127, then send + update in one cycle saturates at 128.
    step(ctl(32'h80000000), 1'b0, 1'b0, 32'h0);
    check("cred_127", 64'(credits), 64'd127);
    step(ctl(32'h80000000), 1'b0, 1'b1, 32'h5A5A0001);
    check("sat_ack", 64'(last_ack), 64'd1);
    check("sat_credits", 64'(credits), 64'd128);

    // Resend holds the packet for three cycles, then the sequence continues.
    step(49'd0, 1'b0, 1'b1, 32'h5A5A0002);
    held = dout;
    for (int i = 0; i < 3; i++) begin
      step(49'd0, 1'b1, 1'b1, 32'h5A5A0003);
      check("resend_dout", 64'(dout), 64'(held));
      check("resend_ack", 64'(last_ack), 64'd0);
      check("resend_credits", 64'(credits), 64'd127);
    end
    step(49'd0, 1'b0, 1'b1, 32'h5A5A0003);
    check("after_resend_ack", 64'(last_ack), 64'd1);
    check("after_resend_addr", 64'(dout[38:32]), 64'(7'(held[38:32] + 7'd1)));

    // Port-0 config is ignored; a valid reconfig applies from the next cycle.
    step(ctl(32'h40000070), 1'b0, 1'b1, 32'h5A5A0004);
    step(ctl(32'h400000A7), 1'b0, 1'b1, 32'h5A5A0005);
    check("old_dest", 64'(dout[47:39]), 64'({5'd5, 4'd3}));
    step(49'd0, 1'b0, 1'b1, 32'h5A5A0006);
    check("new_dest", 64'(dout[47:39]), 64'({5'd10, 4'd7}));

    // Random traffic against the model.
    word = $urandom;
    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: b = ctl({2'b01, 21'($urandom), 5'($urandom), 4'($urandom)});
        1: b = ctl({2'b10, 30'($urandom)});
        2: b = {1'b1, 5'($urandom), 4'($urandom_range(1, 15)), 7'($urandom), 32'($urandom)};
        3: b = ctl({($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 30'($urandom)});
        default: b = {1'b0, 48'({$urandom, $urandom})};
      endcase
      step(b, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), word);
      if (last_ack) word = $urandom;
    end

    // Asynchronous reset mid-stream.
    step(ctl(32'h40000053), 1'b0, 1'b1, 32'h77770001);
    step(49'd0, 1'b0, 1'b1, 32'h77770002);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_dout", 64'(dout), 64'd0);
    check("arst_configured", 64'(configured), 64'd0);
    check("arst_credits", 64'(credits), 64'd128);
    check("arst_ack", 64'(ack_user), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(49'd0, 1'b0, 1'b1, 32'h77770003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
